// File: rtl/neuron_row_mac.sv
// Row-serial 28x28 dot product for one output neuron.
// Three-stage product/sum/accumulate pipeline behind a row-issuing FSM.
module neuron_row_mac #(
  parameter int N_ROWS   = 28,
  parameter int N_COLS   = 28,
  parameter int W_BITS   = 19,
  parameter int P_BITS   = 10,
  parameter int ACC_BITS = 40
) (
  input  logic                       clk,
  input  logic                       GlobalReset,
  input  logic                       start,
  input  logic [W_BITS-1:0]          beta,
  input  logic [N_COLS*W_BITS-1:0]   weight_row,
  input  logic [N_COLS*P_BITS-1:0]   pixel_row,
  output logic [$clog2(N_ROWS)-1:0]  row_sel,
  output logic                       busy,
  output logic [ACC_BITS-1:0]        result,
  output logic                       result_valid,
  output logic                       out_x
);

  localparam int RB = $clog2(N_ROWS);
  localparam int PB = W_BITS + P_BITS + 1;
  localparam int SB = PB + $clog2(N_COLS);

  localparam logic [RB-1:0] LAST_ROW  = RB'(N_ROWS - 1);
  localparam logic [RB-1:0] DRAIN_END = RB'(N_ROWS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_FINAL
  } state_e;

  state_e state_q;
  state_e state_d;

  logic          accept;
  logic          run;
  logic [RB-1:0] cnt_q;
  logic [RB-1:0] cnt_d;

  logic [W_BITS-1:0] beta_q;
  logic [W_BITS-1:0] beta_d;

  logic [PB-1:0] prod_d [N_COLS];
  logic [PB-1:0] prod_q [N_COLS];
  logic          v1_q;
  logic          v1_d;

  logic [SB-1:0] sum_d;
  logic [SB-1:0] sum_q;
  logic          v2_q;
  logic          v2_d;

  logic [ACC_BITS-1:0] acc_q;
  logic [ACC_BITS-1:0] acc_d;

  logic [ACC_BITS-1:0] res_q;
  logic [ACC_BITS-1:0] res_d;
  logic [ACC_BITS-1:0] res_new;
  logic                ox_q;
  logic                ox_d;
  logic                rv_q;
  logic                rv_d;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        if (cnt_q == LAST_ROW) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_END) state_d = S_FINAL;
      end
      S_FINAL: begin
        state_d = start ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs; FINAL may accept the next pass for zero-gap streaming
  always_comb begin
    busy    = 1'b0;
    run     = 1'b0;
    accept  = 1'b0;
    row_sel = '0;
    unique case (state_q)
      S_IDLE: begin
        accept = start;
      end
      S_RUN: begin
        busy    = 1'b1;
        run     = 1'b1;
        row_sel = cnt_q;
      end
      S_DRAIN: begin
        busy = 1'b1;
      end
      S_FINAL: begin
        busy   = 1'b1;
        accept = start;
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q + RB'(1);
    if (accept || state_q == S_IDLE) begin
      cnt_d = '0;
    end
  end

  assign beta_d = accept ? beta : beta_q;

  for (genvar j = 0; j < N_COLS; j++) begin : g_lane
    logic [PB-1:0] w_ext;
    logic [PB-1:0] p_ext;
    logic [W_BITS-1:0] w_lane;
    logic [P_BITS-1:0] p_lane;
    assign w_lane = weight_row[j*W_BITS +: W_BITS];
    assign p_lane = pixel_row[j*P_BITS +: P_BITS];
    assign w_ext  = {{(PB-W_BITS){w_lane[W_BITS-1]}}, w_lane};
    assign p_ext  = {{(PB-P_BITS){1'b0}}, p_lane};
    // low PB bits of the product are exact for signed operands
    assign prod_d[j] = w_ext * p_ext;
  end

  assign v1_d = run;

  always_comb begin
    sum_d = '0;
    for (int j = 0; j < N_COLS; j++) begin
      sum_d = sum_d + {{(SB-PB){prod_q[j][PB-1]}}, prod_q[j]};
    end
  end

  assign v2_d = v1_q;

  always_comb begin
    acc_d = acc_q;
    if (accept) begin
      acc_d = '0;
    end else if (v2_q) begin
      acc_d = acc_q + {{(ACC_BITS-SB){sum_q[SB-1]}}, sum_q};
    end
  end

  assign res_new =
    acc_q + {{(ACC_BITS-W_BITS){beta_q[W_BITS-1]}}, beta_q};

  always_comb begin
    res_d = res_q;
    ox_d  = ox_q;
    rv_d  = 1'b0;
    if (state_q == S_FINAL) begin
      res_d = res_new;
      ox_d  = ~res_new[ACC_BITS-1] & (|res_new);
      rv_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (GlobalReset) begin
      cnt_q  <= '0;
      beta_q <= '0;
      v1_q   <= 1'b0;
      sum_q  <= '0;
      v2_q   <= 1'b0;
      acc_q  <= '0;
      res_q  <= '0;
      ox_q   <= 1'b0;
      rv_q   <= 1'b0;
      for (int j = 0; j < N_COLS; j++) begin
        prod_q[j] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      beta_q <= beta_d;
      v1_q   <= v1_d;
      sum_q  <= sum_d;
      v2_q   <= v2_d;
      acc_q  <= acc_d;
      res_q  <= res_d;
      ox_q   <= ox_d;
      rv_q   <= rv_d;
      for (int j = 0; j < N_COLS; j++) begin
        prod_q[j] <= prod_d[j];
      end
    end
  end

  assign result       = res_q;
  assign out_x        = ox_q;
  assign result_valid = rv_q;

endmodule

// File: tb/tb_neuron_row_mac.sv
// Scoreboard bench for neuron_row_mac.
// Row data is served from arrays indexed by row_sel.
module tb_neuron_row_mac;

  logic          clk = 1'b0;
  logic          GlobalReset;
  logic          start;
  logic [18:0]   beta;
  logic [531:0]  weight_row;
  logic [279:0]  pixel_row;
  logic [4:0]    row_sel;
  logic          busy;
  logic [39:0]   result;
  logic          result_valid;
  logic          out_x;

  neuron_row_mac dut (
    .clk          (clk),
    .GlobalReset  (GlobalReset),
    .start        (start),
    .beta         (beta),
    .weight_row   (weight_row),
    .pixel_row    (pixel_row),
    .row_sel      (row_sel),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .out_x        (out_x)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint v;
    bit     x;
    int     cyc;
  } exp_t;

  exp_t   sbq[$];
  int     w_arr [28][28];
  int     p_arr [28][28];
  int     beta_v;
  longint exp_v;
  longint last_v;
  int     cyc = 0;
  int     checks = 0;
  int     failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // mux model: rows selected combinationally by row_sel
  always_comb begin
    logic [31:0] tw;
    logic [31:0] tp;
    weight_row = '0;
    pixel_row  = '0;
    tw = '0;
    tp = '0;
    if (row_sel < 5'd28) begin
      for (int j = 0; j < 28; j++) begin
        tw = w_arr[row_sel][j];
        tp = p_arr[row_sel][j];
        weight_row[19*j +: 19] = tw[18:0];
        pixel_row[10*j +: 10]  = tp[9:0];
      end
    end
  end

  task automatic chk(input string nm, input longint got,
                     input longint req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0d required %0d", nm, got, req);
    end
  endtask

  function automatic int rnd_w();
    return int'($urandom_range(0, 524287)) - 262144;
  endfunction

  task automatic fill(input int mode);
    for (int r = 0; r < 28; r++) begin
      for (int c = 0; c < 28; c++) begin
        case (mode)
          1: begin w_arr[r][c] = 0; p_arr[r][c] = int'($urandom_range(0, 1023)); end
          2: begin w_arr[r][c] = 1; p_arr[r][c] = 1; end
          3: begin w_arr[r][c] = -262144; p_arr[r][c] = 1023; end
          4: begin w_arr[r][c] = r + 1; p_arr[r][c] = 1; end
          5: begin w_arr[r][c] = 0; p_arr[r][c] = 1023; end
          default: begin
            w_arr[r][c] = rnd_w();
            p_arr[r][c] = int'($urandom_range(0, 1023));
          end
        endcase
      end
    end
    case (mode)
      1: beta_v = 5;
      2, 4, 5: beta_v = 0;
      3: beta_v = -262144;
      default: beta_v = rnd_w();
    endcase
    exp_v = longint'(beta_v);
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++)
        exp_v += longint'(w_arr[r][c]) * longint'(p_arr[r][c]);
  endtask

  // Called mid-cycle (at a negedge); returns at negedge of pass cycle 30.
  task automatic do_pass(input int mode, input bit spam);
    exp_t e;
    fill(mode);
    beta  = beta_v[18:0];
    start = 1'b1;
    e.v   = exp_v;
    e.x   = (exp_v > 0);
    e.cyc = cyc + 1 + 31;
    sbq.push_back(e);
    last_v = exp_v;
    for (int r = 0; r <= 30; r++) begin
      @(negedge clk);
      chk($sformatf("rowsel_c%0d", r), longint'(row_sel),
          (r < 28) ? longint'(r) : 0);
      chk($sformatf("busy_c%0d", r), longint'(busy), 1);
      beta  = 19'(rnd_w());
      start = spam && (r == 5 || r == 20);
    end
  endtask

  task automatic idle_check(input string nm);
    @(negedge clk);
    chk({nm, "_busy"}, longint'(busy), 0);
    chk({nm, "_rowsel"}, longint'(row_sel), 0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    if (result_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: cycle %0d result %0d required none",
                 cyc, $signed(result));
      end else begin
        e = sbq.pop_front();
        chk("result", longint'($signed(result)), e.v);
        chk("out_x", longint'(out_x), longint'(e.x));
        chk("valid_cycle", longint'(cyc), longint'(e.cyc));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t required finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 28; r++)
      for (int c = 0; c < 28; c++) begin
        w_arr[r][c] = 0;
        p_arr[r][c] = 0;
      end
    GlobalReset = 1'b1;
    start = 1'b0;
    beta = '0;
    repeat (3) @(negedge clk);
    chk("rst_rowsel", longint'(row_sel), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_result", longint'(result), 0);
    chk("rst_valid", longint'(result_valid), 0);
    chk("rst_outx", longint'(out_x), 0);
    GlobalReset = 1'b0;
    @(negedge clk);

    for (int m = 1; m <= 5; m++) begin
      do_pass(m, 1'b0);
      idle_check($sformatf("after_m%0d", m));
      repeat (3) @(negedge clk);
      chk("hold_result", longint'($signed(result)), last_v);
    end

    // ignored starts mid-pass, then back-to-back passes
    do_pass(0, 1'b1);
    do_pass(0, 1'b0);
    do_pass(5, 1'b0);
    idle_check("after_b2b");

    // reset in the middle of a pass: no result for it
    @(negedge clk);
    fill(0);
    beta  = beta_v[18:0];
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    GlobalReset = 1'b1;
    @(negedge clk);
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_rowsel", longint'(row_sel), 0);
    chk("midrst_valid", longint'(result_valid), 0);
    GlobalReset = 1'b0;
    repeat (40) @(negedge clk);
    do_pass(0, 1'b0);
    idle_check("after_midrst");

    // reset and start on the same edge: reset wins
    @(negedge clk);
    start = 1'b1;
    GlobalReset = 1'b1;
    @(negedge clk);
    chk("rst_start_busy", longint'(busy), 0);
    start = 1'b0;
    GlobalReset = 1'b0;
    @(negedge clk);
    chk("rst_start_busy2", longint'(busy), 0);

    for (int k = 0; k < 4; k++) begin
      do_pass(0, k[0]);
    end
    repeat (40) @(negedge clk);
    chk("sb_empty", longint'(sbq.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
